// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array readout path.
// Holds accumulator/output width defaults and the requant rounding constant.
package systolic_pkg;

  localparam int ACC_W_DEF = 20;
  localparam int OUT_W_DEF = 8;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  // Half-LSB of the shifted result; zero when no shift is applied.
  function automatic int round_const(input int sh);
    if (sh == 0) return 0;
    return 1 << (sh - 1);
  endfunction

endpackage

// File: rtl/systolic_drain_requant_sat.sv
// Combinational requantizer: round-half-up right shift, then clip to int OUT_W.
// Result is computed one bit wider than the accumulator so rounding never wraps.
module requant_sat
  import systolic_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [SHIFT_W-1:0]      shift,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  logic signed [ACC_W:0]     ext;
  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W:0]     r;
  logic [ACC_W-OUT_W+1:0]    hi;
  logic                      pos_ovf;
  logic                      neg_ovf;

  always_comb begin
    ext = {acc[ACC_W-1], acc};
    sum = ext + $signed((ACC_W+1)'(round_const(int'(shift))));
    r   = sum >>> shift;
    // Bits above the output sign must all equal it, else the value clipped.
    hi      = r[ACC_W:OUT_W-1];
    pos_ovf = !r[ACC_W] && (|hi);
    neg_ovf = r[ACC_W] && !(&hi);
    sat     = pos_ovf || neg_ovf;
    unique case (1'b1)
      pos_ovf: data = {1'b0, {(OUT_W-1){1'b1}}};
      neg_ovf: data = {1'b1, {(OUT_W-1){1'b0}}};
      default: data = r[OUT_W-1:0];
    endcase
  end

endmodule

// File: rtl/systolic_drain.sv
// Snapshots a row of MAC accumulators and streams them out as int8 over valid/ready.
// clear_acc lets the array start the next tile while this one drains.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int NUM_ACC = 4,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_ACC*ACC_W-1:0]   acc_in,
  input  logic                       drain_start,
  input  logic [SHIFT_W-1:0]         shift_amt,
  output logic                       clear_acc,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(NUM_ACC)-1:0] out_index,
  output logic                       out_last,
  output logic                       out_sat,
  output logic [7:0]                 sat_count
);

  localparam int IDX_W = $clog2(NUM_ACC);

  drain_state_t                   state_q, state_d;
  logic [NUM_ACC-1:0][ACC_W-1:0]  buf_q, buf_d;
  logic [SHIFT_W-1:0]             shift_q, shift_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [7:0]                     sat_cnt_q, sat_cnt_d;
  logic                           clear_q, clear_d;

  logic                           is_last;
  logic                           streaming;
  logic signed [OUT_W-1:0]        rq_data;
  logic                           rq_sat;

  requant_sat #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_requant (
    .acc  (buf_q[idx_q]),
    .shift(shift_q),
    .data (rq_data),
    .sat  (rq_sat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      sat_cnt_q <= '0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      sat_cnt_q <= sat_cnt_d;
      clear_q   <= clear_d;
    end
  end

  assign streaming = (state_q == STREAM);
  assign is_last   = (idx_q == IDX_W'(NUM_ACC - 1));

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    sat_cnt_d = sat_cnt_q;
    clear_d   = 1'b0;
    unique case (1'b1)
      !streaming: begin
        if (drain_start) begin
          state_d   = STREAM;
          buf_d     = acc_in;
          shift_d   = shift_amt;
          idx_d     = '0;
          sat_cnt_d = '0;
          clear_d   = 1'b1;
        end
      end
      streaming: begin
        if (out_ready) begin
          idx_d = is_last ? '0 : idx_q + 1'b1;
          if (rq_sat && (sat_cnt_q != 8'hFF))
            sat_cnt_d = sat_cnt_q + 8'd1;
          if (is_last)
            state_d = IDLE;
        end
      end
    endcase
  end

  // Data lines are gated so the idle bus reads as zero.
  assign out_valid = streaming;
  assign busy      = streaming;
  assign clear_acc = clear_q;
  assign out_data  = streaming ? rq_data : '0;
  assign out_index = idx_q;
  assign out_last  = streaming && is_last;
  assign out_sat   = streaming && rq_sat;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: a reference model queues expected
// elements at each accepted drain, a negedge monitor pops and compares.
module tb_systolic_drain;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int OW = 8;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N*AW-1:0] acc_in = '0;
  logic          drain_start = 1'b0;
  logic [SW-1:0] shift_amt = '0;
  logic          out_ready = 1'b0;
  logic          clear_acc;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [1:0]    out_index;
  logic          out_last;
  logic          out_sat;
  logic [7:0]    sat_count;

  always #5 clock = ~clock;

  systolic_drain #(
    .NUM_ACC(N), .ACC_W(AW), .OUT_W(OW), .SHIFT_W(SW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .acc_in     (acc_in),
    .drain_start(drain_start),
    .shift_amt  (shift_amt),
    .clear_acc  (clear_acc),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_sat    (out_sat),
    .sat_count  (sat_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int data;
    int idx;
    bit last;
    bit sat;
    int satcnt;
  } exp_t;

  exp_t sbq[$];
  bit   active = 1'b0;
  bit   exp_clear = 1'b0;
  int   xfers = 0;
  bit   rand_ready = 1'b0;

  // Reference requant: floor((a + half) / 2^s), then clip to int8.
  function automatic void ref_requant(input int a, input int s,
                                      output int d, output bit sat);
    longint num, den, q;
    num = a;
    den = longint'(1) << s;
    if (s > 0) num = num + den / 2;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    if (q > 127) begin
      d = 127; sat = 1'b1;
    end else if (q < -128) begin
      d = -128; sat = 1'b1;
    end else begin
      d = int'(q); sat = 1'b0;
    end
  endfunction

  // Reference model: tracks whether a drain is in flight.
  bit   m_was;
  int   m_cnt, m_s, m_a, m_d;
  bit   m_sat;
  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      active = 1'b0;
      exp_clear = 1'b0;
      xfers = 0;
      sbq.delete();
    end else begin
      m_was = active;
      exp_clear = 1'b0;
      if (m_was && out_ready) begin
        xfers++;
        if (xfers == N) begin
          active = 1'b0;
          xfers = 0;
        end
      end
      if (!m_was && drain_start) begin
        m_cnt = 0;
        m_s = int'(shift_amt);
        for (int i = 0; i < N; i++) begin
          m_a = int'($signed(acc_in[i*AW +: AW]));
          ref_requant(m_a, m_s, m_d, m_sat);
          sbq.push_back('{m_d, i, (i == N-1), m_sat, m_cnt});
          if (m_sat && m_cnt < 255) m_cnt++;
        end
        active = 1'b1;
        exp_clear = 1'b1;
      end
    end
  end

  // Monitor: handshake/strobe checks plus scoreboard pops.
  bit         stall = 1'b0;
  logic [OW-1:0] h_data;
  logic [1:0] h_idx;
  logic       h_last, h_sat;
  exp_t       e;
  initial forever begin
    @(negedge clock);
    chk("out_valid", out_valid, active);
    chk("busy", busy, active);
    chk("clear_acc", clear_acc, exp_clear);
    if (stall && reset_n) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, h_data);
      chk("hold_index", out_index, h_idx);
      chk("hold_last", out_last, h_last);
      chk("hold_sat", out_sat, h_sat);
    end
    if (reset_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("out_data", $signed(out_data), e.data);
        chk("out_index", out_index, e.idx);
        chk("out_last", out_last, e.last);
        chk("out_sat", out_sat, e.sat);
        chk("sat_count", sat_count, e.satcnt);
      end
    end
    stall  = reset_n && out_valid && !out_ready;
    h_data = out_data;
    h_idx  = out_index;
    h_last = out_last;
    h_sat  = out_sat;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    acc_in[0*AW +: AW] = AW'(a0);
    acc_in[1*AW +: AW] = AW'(a1);
    acc_in[2*AW +: AW] = AW'(a2);
    acc_in[3*AW +: AW] = AW'(a3);
  endtask

  task automatic rand_acc();
    int v;
    int sel;
    for (int i = 0; i < N; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: v = int'($urandom_range(0, 600)) - 300;
        1: v = int'($signed(AW'($urandom)));
        2: v = ($urandom_range(0, 1) == 0) ? 524287 : -524288;
        default: v = int'($urandom_range(0, 70000)) - 35000;
      endcase
      acc_in[i*AW +: AW] = AW'(v);
    end
    shift_amt = SW'($urandom_range(0, 15));
  endtask

  task automatic start_drain();
    drain_start = 1'b1;
    cycle();
    drain_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (active && k < 300) begin
      cycle();
      k++;
    end
    if (active) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear", clear_acc, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    cycle();
    reset_n = 1'b1;
    cycle();

    // T1
    out_ready = 1'b1;
    shift_amt = 4'd0;
    set_acc(100, -100, 300, -5);
    start_drain();
    wait_idle();
    chk("t1_sat_count", sat_count, 1);
    cycle();

    // T2
    shift_amt = 4'd2;
    set_acc(6, -6, 524287, -524288);
    start_drain();
    wait_idle();
    chk("t2_sat_count", sat_count, 2);
    cycle();

    // T3: stall on idx1, then random ready
    rand_acc();
    out_ready = 1'b1;
    start_drain();
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    chk("t3_stall_index", out_index, 1);
    rand_ready = 1'b1;
    wait_idle();
    cycle();

    // T4: restart pulses and input churn mid-stream
    rand_acc();
    start_drain();
    for (int i = 0; i < 3; i++) begin
      drain_start = 1'b1;
      rand_acc();
      cycle();
    end
    drain_start = 1'b0;
    wait_idle();
    cycle();

    // T5: reset after the idx1 transfer
    rand_ready = 1'b0;
    out_ready = 1'b1;
    rand_acc();
    start_drain();
    cycle();
    cycle();
    reset_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_clear", clear_acc, 0);
    cycle();
    reset_n = 1'b1;
    cycle();
    rand_acc();
    start_drain();
    wait_idle();

    // T6: back-to-back drain in the first idle cycle
    rand_acc();
    start_drain();
    chk("t6_clear_first", clear_acc, 1);
    wait_idle();
    rand_acc();
    start_drain();
    chk("t6_clear_second", clear_acc, 1);
    wait_idle();

    // Random drains
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) cycle();
      rand_acc();
      start_drain();
      wait_idle();
    end
    rand_ready = 1'b0;
    cycle();
    cycle();
    chk("sb_leftover", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
